// File: rtl/monitor_pkg.sv
// Shared constants and state encodings for the UART byte-stream monitor.
package monitor_pkg;

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_G = 8'h47;
  localparam logic [7:0] CMD_H = 8'h48;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  typedef enum logic [4:0] {
    S_IDLE,
    S_AH,
    S_AL,
    S_LH,
    S_LL,
    S_WDATA,
    S_WSTB,
    S_RADDR,
    S_RWAIT,
    S_RSEND,
    S_TXHOLD,
    S_TXWAIT,
    S_ACK,
    S_GO1,
    S_GO2,
    S_RUN
  } mon_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_HOLD,
    TX_WAIT
  } tx_state_t;

  // First bytes that open a command; anything else is answered with NAK.
  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_W) || (b == CMD_R) || (b == CMD_G);
  endfunction

endpackage

// File: rtl/monitor_tx.sv
// UART transmit handshake: one tx_start pulse, one hold cycle while the
// transmitter raises busy, then wait for busy to drop.
import monitor_pkg::*;

module monitor_tx (
  input  logic       clk,
  input  logic       reset,
  input  logic       send_i,
  input  logic [7:0] data_i,
  input  logic       tx_busy_i,
  output logic       tx_start_o,
  output logic [7:0] tx_data_o,
  output logic       done_o
);

  tx_state_t  state_q;
  logic       tx_start_q;
  logic [7:0] tx_data_q;

  // Launch a byte only when the transmitter is idle, then track its busy window.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= TX_IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        TX_IDLE: begin
          if (send_i && !tx_busy_i) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= data_i;
            state_q    <= TX_HOLD;
          end
        end
        // busy only rises the cycle after tx_start, so do not sample it yet
        TX_HOLD: state_q <= TX_WAIT;
        TX_WAIT: begin
          if (!tx_busy_i) state_q <= TX_IDLE;
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

  assign tx_start_o = tx_start_q;
  assign tx_data_o  = tx_data_q;
  assign done_o     = (state_q == TX_WAIT) && !tx_busy_i;

endmodule

// File: rtl/cpu_monitor.sv
// Byte-stream monitor between the UART and the CPU/program memory: loads and
// dumps memory, sets the CPU start address and runs the CPU until it halts.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a command byte
// AH/AL   | collecting the 16-bit address (upper bits dropped)
// LH/LL   | collecting the 16-bit length
// WDATA   | waiting for the next write data byte
// WSTB    | mem_write strobe cycle, address advances afterwards
// RADDR   | mem_raddr presented
// RWAIT   | registered memory read in flight
// RSEND   | read data handed to the transmitter once it is idle
// TXHOLD  | tx_start cycle, busy not yet valid
// TXWAIT  | waiting for the transmitter to finish
// ACK     | sending ACK or NAK
// GO1/GO2 | start address settled, CPU still in reset
// RUN     | CPU owns memory until it reports halted
import monitor_pkg::*;

module cpu_monitor #(
  parameter int addr_width = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_busy,
  output logic [addr_width-1:0] mem_raddr,
  input  logic [7:0]            mem_data_out,
  output logic [addr_width-1:0] mem_waddr,
  output logic [7:0]            mem_data_in,
  output logic                  mem_write,
  output logic                  mem_sel,
  output logic [addr_width-1:0] start_address,
  output logic                  cpu_reset,
  output logic                  cpu_halt,
  input  logic                  cpu_halted
);

  // Only the address-high bits that land inside the memory are kept;
  // supports addr_width from 9 to 16.
  localparam int AHW = addr_width - 8;
  localparam logic [addr_width-1:0] ADDR_ONE = 1;

  mon_state_t            state_q;
  logic [7:0]            cmd_q;
  logic [AHW-1:0]        ah_q;
  logic [7:0]            lh_q;
  logic [addr_width-1:0] addr_q;
  logic [15:0]           rem_q;
  logic [7:0]            ack_byte_q;
  logic                  tx_is_ack_q;
  logic [addr_width-1:0] mem_raddr_q;
  logic [addr_width-1:0] mem_waddr_q;
  logic [7:0]            mem_data_in_q;
  logic                  mem_write_q;
  logic [addr_width-1:0] start_address_q;
  logic                  cpu_reset_q;
  logic                  cpu_halt_q;
  logic                  mem_sel_q;

  logic [addr_width-1:0] addr_rx;
  logic [15:0]           len_rx;
  logic                  tx_send;
  logic [7:0]            tx_byte;
  logic                  tx_done;

  assign addr_rx = {ah_q, rx_data};
  assign len_rx  = {lh_q, rx_data};
  assign tx_send = (state_q == S_RSEND) || (state_q == S_ACK);
  assign tx_byte = (state_q == S_RSEND) ? mem_data_out : ack_byte_q;

  monitor_tx u_tx (
    .clk        (clk),
    .reset      (reset),
    .send_i     (tx_send),
    .data_i     (tx_byte),
    .tx_busy_i  (tx_busy),
    .tx_start_o (tx_start),
    .tx_data_o  (tx_data),
    .done_o     (tx_done)
  );

  // Command parser, memory access sequencing and CPU run control.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      cmd_q           <= 8'h00;
      ah_q            <= '0;
      lh_q            <= 8'h00;
      addr_q          <= '0;
      rem_q           <= 16'h0000;
      ack_byte_q      <= ACK;
      tx_is_ack_q     <= 1'b0;
      mem_raddr_q     <= '0;
      mem_waddr_q     <= '0;
      mem_data_in_q   <= 8'h00;
      mem_write_q     <= 1'b0;
      start_address_q <= '0;
      cpu_reset_q     <= 1'b1;
      cpu_halt_q      <= 1'b0;
      mem_sel_q       <= 1'b1;
    end else begin
      mem_write_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rx_valid) begin
            if (is_cmd(rx_data)) begin
              cmd_q   <= rx_data;
              state_q <= S_AH;
            end else begin
              ack_byte_q <= NAK;
              state_q    <= S_ACK;
            end
          end
        end
        S_AH: begin
          if (rx_valid) begin
            ah_q    <= rx_data[AHW-1:0];
            state_q <= S_AL;
          end
        end
        S_AL: begin
          if (rx_valid) begin
            addr_q <= addr_rx;
            if (cmd_q == CMD_G) begin
              start_address_q <= addr_rx;
              state_q         <= S_GO1;
            end else begin
              state_q <= S_LH;
            end
          end
        end
        S_LH: begin
          if (rx_valid) begin
            lh_q    <= rx_data;
            state_q <= S_LL;
          end
        end
        S_LL: begin
          if (rx_valid) begin
            rem_q <= len_rx;
            if (len_rx == 16'h0000) begin
              ack_byte_q <= ACK;
              state_q    <= S_ACK;
            end else if (cmd_q == CMD_W) begin
              state_q <= S_WDATA;
            end else begin
              mem_raddr_q <= addr_q;
              state_q     <= S_RADDR;
            end
          end
        end
        S_WDATA: begin
          if (rx_valid) begin
            mem_waddr_q   <= addr_q;
            mem_data_in_q <= rx_data;
            mem_write_q   <= 1'b1;
            rem_q         <= rem_q - 16'd1;
            state_q       <= S_WSTB;
          end
        end
        S_WSTB: begin
          addr_q <= addr_q + ADDR_ONE;
          if (rem_q != 16'h0000) begin
            state_q <= S_WDATA;
          end else begin
            ack_byte_q <= ACK;
            state_q    <= S_ACK;
          end
        end
        S_RADDR: state_q <= S_RWAIT;
        S_RWAIT: state_q <= S_RSEND;
        S_RSEND: begin
          // the tx block accepts mem_data_out in this same cycle
          if (!tx_busy) begin
            rem_q       <= rem_q - 16'd1;
            addr_q      <= addr_q + ADDR_ONE;
            tx_is_ack_q <= 1'b0;
            state_q     <= S_TXHOLD;
          end
        end
        S_TXHOLD: state_q <= S_TXWAIT;
        S_TXWAIT: begin
          if (tx_done) begin
            if (tx_is_ack_q) begin
              state_q <= S_IDLE;
            end else if (rem_q != 16'h0000) begin
              mem_raddr_q <= addr_q;
              state_q     <= S_RADDR;
            end else begin
              ack_byte_q <= ACK;
              state_q    <= S_ACK;
            end
          end
        end
        S_ACK: begin
          if (!tx_busy) begin
            tx_is_ack_q <= 1'b1;
            state_q     <= S_TXHOLD;
          end
        end
        S_GO1: state_q <= S_GO2;
        S_GO2: begin
          cpu_reset_q <= 1'b0;
          mem_sel_q   <= 1'b0;
          state_q     <= S_RUN;
        end
        S_RUN: begin
          // halted wins over a coincident H byte
          if (cpu_halted) begin
            cpu_reset_q <= 1'b1;
            mem_sel_q   <= 1'b1;
            cpu_halt_q  <= 1'b0;
            ack_byte_q  <= ACK;
            state_q     <= S_ACK;
          end else if (rx_valid && (rx_data == CMD_H)) begin
            cpu_halt_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_raddr     = mem_raddr_q;
  assign mem_waddr     = mem_waddr_q;
  assign mem_data_in   = mem_data_in_q;
  assign mem_write     = mem_write_q;
  assign mem_sel       = mem_sel_q;
  assign start_address = start_address_q;
  assign cpu_reset     = cpu_reset_q;
  assign cpu_halt      = cpu_halt_q;

endmodule
